// File: rtl/iter_unit.sv
// Iteration engine: applies a selectable step function to a WIDTH-bit state once per
// clock, running seeded jobs of a requested length under valid/ready handshakes.
module iter_unit #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS   = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_STATE = '1,
  parameter bit               FREE_RUN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_seed,
  input  logic [CNT_W-1:0] in_count,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_state,
  output logic [WIDTH-1:0] cur_state,
  output logic             busy
);

  // state | meaning
  // IDLE  | ready for a job; state free-runs with the latched mode (or holds)
  // RUN   | applying f once per edge, rem counts down to 1
  // HOLD  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_e;

  localparam logic [1:0] MODE_NOT  = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_ROTL = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // Rotation written as a shift pair so WIDTH=1 degenerates to identity.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_NOT:  r = ~s;
      MODE_INC:  r = s + WIDTH'(1);
      MODE_ROTL: r = (s << 1) | (s >> (WIDTH - 1));
      MODE_LFSR: r = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
      default:   r = s;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= RESET_STATE;
      mode_q  <= MODE_NOT;
      rem_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_seed;
          mode_d  = in_mode;
          rem_d   = in_count;
          fsm_d   = (in_count == '0) ? HOLD : RUN;
        end else if (FREE_RUN) begin
          state_d = step(state_q, mode_q);
        end
      end
      RUN: begin
        state_d = step(state_q, mode_q);
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) fsm_d = HOLD;
      end
      HOLD: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == HOLD);
  assign busy      = (fsm_q == RUN);
  assign out_state = state_q;
  assign cur_state = state_q;

endmodule
